// File: rtl/srcnn_div_pkg.sv
// rtl/srcnn_div_pkg.sv - shared types, widths and saturation helper for the sequential divider
//
// Contents:
//   div_state_e    FSM state encoding (IDLE, CALC, DONE)
//   DIV_*_W        default operand widths and the bit-counter width
//   sat_quot()     clamps the full-width quotient to the output width, flags overflow
package srcnn_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_DIVIDEND_W = 12;
  localparam int DIV_DIVISOR_W  = 3;
  localparam int DIV_QUOTIENT_W = 10;
  localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

  // Returns {ovf, quot}. Any set bit above the output width means the true
  // quotient does not fit, so the output clamps to all-ones.
  function automatic logic [DIV_QUOTIENT_W:0] sat_quot(
    input logic [DIV_DIVIDEND_W-1:0] q
  );
    logic                      ovf;
    logic [DIV_QUOTIENT_W-1:0] qs;
    ovf = |q[DIV_DIVIDEND_W-1:DIV_QUOTIENT_W];
    qs  = ovf ? {DIV_QUOTIENT_W{1'b1}} : q[DIV_QUOTIENT_W-1:0];
    return {ovf, qs};
  endfunction

endpackage

// File: rtl/srcnn_div_step.sv
// rtl/srcnn_div_step.sv - one combinational restoring-division step
//
// Ports:
//   rem_in    partial remainder before the step (always < divisor)
//   bit_in    next dividend bit, MSB first
//   divisor   divisor operand
//   rem_out   partial remainder after the step
//   q_bit     quotient bit produced by this step
module srcnn_div_step #(
  parameter int DIVISOR_WIDTH = 3
) (
  input  logic [DIVISOR_WIDTH:0]   rem_in,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   rem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] shifted;
  logic [DIVISOR_WIDTH:0] divisor_ext;

  // rem_in < divisor, so its top bit is zero and the left shift cannot lose data.
  assign shifted     = (rem_in << 1) | {{DIVISOR_WIDTH{1'b0}}, bit_in};
  assign divisor_ext = {1'b0, divisor};
  assign q_bit       = (shifted >= divisor_ext);
  assign rem_out     = q_bit ? (shifted - divisor_ext) : shifted;

endmodule

// File: rtl/srcnn_udiv_seq_12ns_3ns_10.sv
// rtl/srcnn_udiv_seq_12ns_3ns_10.sv - multi-cycle unsigned restoring divider with valid/ready handshakes
//
// Optional build macro: SRCNN_DIV_ROUND_EN (round-half-up quotient on completion).
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   synchronous active-low reset
//   in_valid   operands valid
//   in_ready   divider idle and able to accept operands
//   din0       unsigned dividend
//   din1       unsigned divisor
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   quot       quotient, saturated to QUOTIENT_WIDTH
//   rem        truncating remainder
//   ovf        quotient saturated
//   div0       divisor was zero
module srcnn_udiv_seq_12ns_3ns_10
  import srcnn_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIV_DIVISOR_W,
  parameter int QUOTIENT_WIDTH = DIV_QUOTIENT_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      div0
);

  div_state_e state, state_next;

  logic [DIVIDEND_WIDTH-1:0] dividend_sr;
  logic [DIVISOR_WIDTH-1:0]  divisor_r;
  logic [DIVISOR_WIDTH:0]    partial_r;
  logic [DIVIDEND_WIDTH-1:0] quot_full;
  logic [DIV_CNT_W-1:0]      cnt;

  logic [DIVISOR_WIDTH:0]    partial_next;
  logic                      q_bit;
  logic [DIVIDEND_WIDTH-1:0] quot_final;
  logic [QUOTIENT_WIDTH-1:0] quot_res;
  logic                      ovf_res;

  logic accept;
  logic last_step;
  logic handshake;

  srcnn_div_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .rem_in  (partial_r),
    .bit_in  (dividend_sr[DIVIDEND_WIDTH-1]),
    .divisor (divisor_r),
    .rem_out (partial_next),
    .q_bit   (q_bit)
  );

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign last_step  = (state == CALC) && (cnt == '0);
  assign handshake  = out_valid && out_ready;

  // Quotient including the bit produced in the current step; only meaningful
  // on the last step, where it is the complete quotient.
  assign quot_final = (quot_full << 1) | {{(DIVIDEND_WIDTH-1){1'b0}}, q_bit};

  // Result formatting for DONE entry: saturation, then optional rounding.
  always_comb begin
    {ovf_res, quot_res} = sat_quot(quot_final);
`ifdef SRCNN_DIV_ROUND_EN
    // Final remainder is below the divisor, so doubling it fits in DIVISOR_WIDTH+1 bits.
    if (({partial_next[DIVISOR_WIDTH-1:0], 1'b0} >= {1'b0, divisor_r}) && !ovf_res) begin
      if (quot_res == {QUOTIENT_WIDTH{1'b1}}) begin
        ovf_res = 1'b1;
      end else begin
        quot_res = quot_res + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (din1 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dividend_sr <= '0;
      divisor_r   <= '0;
      partial_r   <= '0;
      quot_full   <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      ovf         <= 1'b0;
      div0        <= 1'b0;
    end else begin
      if (accept) begin
        dividend_sr <= din0;
        divisor_r   <= din1;
        partial_r   <= '0;
        quot_full   <= '0;
        cnt         <= DIV_CNT_W'(DIVIDEND_WIDTH - 1);
        if (din1 == '0) begin
          out_valid <= 1'b1;
          quot      <= {QUOTIENT_WIDTH{1'b1}};
          rem       <= din0[DIVISOR_WIDTH-1:0];
          ovf       <= 1'b0;
          div0      <= 1'b1;
        end
      end

      if (state == CALC) begin
        dividend_sr <= dividend_sr << 1;
        partial_r   <= partial_next;
        quot_full   <= quot_final;
        cnt         <= cnt - 1'b1;
      end

      if (last_step) begin
        out_valid <= 1'b1;
        quot      <= quot_res;
        rem       <= partial_next[DIVISOR_WIDTH-1:0];
        ovf       <= ovf_res;
        div0      <= 1'b0;
      end

      // Result fields hold after the handshake; only the valid flag drops.
      if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_srcnn_udiv_seq_12ns_3ns_10.sv
// tb/tb_srcnn_udiv_seq_12ns_3ns_10.sv - directed self-checking bench for the sequential divider
module tb_srcnn_udiv_seq_12ns_3ns_10;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] din0;
  logic [2:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  quot;
  logic [2:0]  rem;
  logic        ovf;
  logic        div0;

  int checks;
  int failures;

  srcnn_udiv_seq_12ns_3ns_10 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .div0      (div0)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Presents one operand pair and returns the number of edges from the
  // accepting edge (counted as 1) to the first cycle with out_valid high.
  // Returns 0 if in_ready never came or the result never appeared.
  task automatic start_op(input logic [11:0] a, input logic [2:0] b, output int edges);
    int w;
    edges = 0;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge ap_clk); #1;
      w++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0 = '0;
    din1 = '0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge ap_clk); #1;
      edges++;
    end
    if (!out_valid) edges = 0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required in_ready=1 out_valid=0", in_ready, out_valid);
    end
    checks++;
    if (quot !== 10'd0 || rem !== 3'd0 || ovf !== 1'b0 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: quot=%0d rem=%0d ovf=%b div0=%b, required all zero", quot, rem, ovf, div0);
    end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic();
    int e;
    logic [9:0] exp_q;
    start_op(12'd100, 3'd3, e);
    checks++;
    if (e !== 13) begin
      failures++;
      $display("FAIL latency_100_3: edges=%0d, required 13", e);
    end
    checks++;
    if (quot !== 10'd33 || rem !== 3'd1 || ovf !== 1'b0 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL div_100_3: quot=%0d rem=%0d ovf=%b div0=%b, required 33 1 0 0", quot, rem, ovf, div0);
    end
    @(posedge ap_clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_100_3: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end

`ifdef SRCNN_DIV_ROUND_EN
    exp_q = 10'd6;
`else
    exp_q = 10'd5;
`endif
    start_op(12'd11, 3'd2, e);
    checks++;
    if (e !== 13 || quot !== exp_q || rem !== 3'd1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL div_11_2: edges=%0d quot=%0d rem=%0d ovf=%b, required 13 %0d 1 0", e, quot, rem, ovf, exp_q);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_overflow();
    int e;
    start_op(12'd4095, 3'd1, e);
    checks++;
    if (e !== 13 || quot !== 10'd1023 || rem !== 3'd0 || ovf !== 1'b1 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_4095_1: edges=%0d quot=%0d rem=%0d ovf=%b div0=%b, required 13 1023 0 1 0", e, quot, rem, ovf, div0);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_div0();
    int e;
    start_op(12'd7, 3'd0, e);
    checks++;
    if (e !== 1) begin
      failures++;
      $display("FAIL latency_div0: edges=%0d, required 1", e);
    end
    checks++;
    if (quot !== 10'd1023 || rem !== 3'd7 || div0 !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL div0_7_0: quot=%0d rem=%0d div0=%b ovf=%b, required 1023 7 1 0", quot, rem, div0, ovf);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back();
    int e;
    int bad;
    logic [9:0] q0;
    logic [2:0] r0;
    out_ready = 1'b0;
    start_op(12'd100, 3'd3, e);
    checks++;
    if (e !== 13 || quot !== 10'd33 || rem !== 3'd1) begin
      failures++;
      $display("FAIL bp_result: edges=%0d quot=%0d rem=%0d, required 13 33 1", e, quot, rem);
    end
    q0 = quot;
    r0 = rem;
    in_valid = 1'b1;
    din0 = 12'd50;
    din1 = 3'd5;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== q0 || rem !== r0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold: unstable cycles=%0d, required 0", bad);
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    start_op(12'd4095, 3'd7, e);
    checks++;
    if (e !== 13 || quot !== 10'd585 || rem !== 3'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_4095_7: edges=%0d quot=%0d rem=%0d ovf=%b, required 13 585 0 0", e, quot, rem, ovf);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    int e;
    int seen;
    in_valid = 1'b1;
    din0 = 12'd100;
    din1 = 3'd3;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== 10'd0) begin
      failures++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b quot=%0d, required 1 0 0", in_ready, out_valid, quot);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst_noresult: out_valid cycles=%0d, required 0", seen);
    end
    start_op(12'd9, 3'd4, e);
    checks++;
    if (e !== 13 || quot !== 10'd2 || rem !== 3'd1 || ovf !== 1'b0 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_9_4: edges=%0d quot=%0d rem=%0d ovf=%b div0=%b, required 13 2 1 0 0", e, quot, rem, ovf, div0);
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_div0();
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
